// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the flag/branch unit:
// CCR bit positions, jump type codes and the jump condition helper.
package flag_branch_unit_pkg;

    localparam int CCR_W = 4;
    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    localparam logic [2:0] JMP_NONE = 3'd0;
    localparam logic [2:0] JMP_JZ   = 3'd1;
    localparam logic [2:0] JMP_JN   = 3'd2;
    localparam logic [2:0] JMP_JC   = 3'd3;
    localparam logic [2:0] JMP_JMP  = 3'd4;

    // Condition met for a jump type against a CCR value; reserved codes never jump.
    function automatic logic jump_cond(
        input logic [2:0]       jtype,
        input logic [CCR_W-1:0] flags
    );
        logic r;
        r = 1'b0;
        case (jtype)
            JMP_JZ:  r = flags[CCR_Z];
            JMP_JN:  r = flags[CCR_N];
            JMP_JC:  r = flags[CCR_C];
            JMP_JMP: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved CCR values for nested interrupts.
// Top of stack is always entry 0; push/pop shift the array.
module flag_shadow_stack
    import flag_branch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = CCR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_bad;

    // Push and pop together is a tail-chain: the stack is left alone.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~i_pop & ~o_full;
    assign w_pop_ok  = i_pop & ~i_push & ~o_empty;
    assign w_bad     = (i_push & ~i_pop & o_full) | (i_pop & ~i_push & o_empty);
    assign o_dout    = r_mem[0];
    assign o_err     = r_err;

    // Stack storage, occupancy count and sticky misuse flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_bad) begin
                r_err <= 1'b1;
            end
            if (w_push_ok) begin
                r_mem[0] <= i_din;
                for (int i = 1; i < DEPTH; i++) begin
                    r_mem[i] <= r_mem[i-1];
                end
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Condition-code register with ALU updates, SETC/CLRC, interrupt save/restore
// and conditional jump resolution against the registered flags.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             aluZero,
    input  logic             aluNegative,
    input  logic             aluCarry,
    input  logic             aluOverflow,
    input  logic [CCR_W-1:0] flagUpdateMask,
    input  logic             setCarry,
    input  logic             clearCarry,
    input  logic             jumpValid,
    input  logic [2:0]       jumpType,
    input  logic             intSave,
    input  logic             intRestore,
    output logic [CCR_W-1:0] ccr,
    output logic             takeJump,
    output logic             stackFull,
    output logic             stackEmpty,
    output logic             errStack
);

    logic [CCR_W-1:0] r_ccr;
    logic [CCR_W-1:0] w_alu;
    logic [CCR_W-1:0] w_pop_val;
    logic [CCR_W-1:0] w_clr;
    logic [CCR_W-1:0] w_next;
    logic             w_pop_ok;

    assign w_alu    = {aluOverflow, aluCarry, aluNegative, aluZero};
    assign ccr      = r_ccr;
    assign takeJump = rst_n & jumpValid & jump_cond(jumpType, r_ccr);
    assign w_pop_ok = intRestore & ~intSave & ~stackEmpty;

    flag_shadow_stack #(
        .DEPTH (SHADOW_DEPTH),
        .WIDTH (CCR_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (intSave),
        .i_pop   (intRestore),
        .i_din   (r_ccr),
        .o_dout  (w_pop_val),
        .o_full  (stackFull),
        .o_empty (stackEmpty),
        .o_err   (errStack)
    );

    // Flag consumed by a taken conditional jump; JMP consumes nothing.
    always_comb begin
        w_clr = '0;
        if (takeJump) begin
            case (jumpType)
                JMP_JZ:  w_clr[CCR_Z] = 1'b1;
                JMP_JN:  w_clr[CCR_N] = 1'b1;
                JMP_JC:  w_clr[CCR_C] = 1'b1;
                default: w_clr = '0;
            endcase
        end
    end

    // Next CCR, applied lowest priority first so later writes win.
    always_comb begin
        w_next = (r_ccr & ~flagUpdateMask) | (w_alu & flagUpdateMask);
        if (clearCarry) begin
            w_next[CCR_C] = 1'b0;
        end else if (setCarry) begin
            w_next[CCR_C] = 1'b1;
        end
        w_next = w_next & ~w_clr;
        if (w_pop_ok) begin
            w_next = w_pop_val;
        end
    end

    // Condition-code register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ccr <= '0;
        end else begin
            r_ccr <= w_next;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: expected results are queued per
// step and compared against the DUT after the clock edge.
module tb_flag_branch_unit;

    typedef struct {
        string      tag;
        logic       take;
        logic [3:0] ccr;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       aluZero, aluNegative, aluCarry, aluOverflow;
    logic [3:0] flagUpdateMask;
    logic       setCarry, clearCarry;
    logic       jumpValid;
    logic [2:0] jumpType;
    logic       intSave, intRestore;
    logic [3:0] ccr;
    logic       takeJump, stackFull, stackEmpty, errStack;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    flag_branch_unit #(.SHADOW_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .aluZero        (aluZero),
        .aluNegative    (aluNegative),
        .aluCarry       (aluCarry),
        .aluOverflow    (aluOverflow),
        .flagUpdateMask (flagUpdateMask),
        .setCarry       (setCarry),
        .clearCarry     (clearCarry),
        .jumpValid      (jumpValid),
        .jumpType       (jumpType),
        .intSave        (intSave),
        .intRestore     (intRestore),
        .ccr            (ccr),
        .takeJump       (takeJump),
        .stackFull      (stackFull),
        .stackEmpty     (stackEmpty),
        .errStack       (errStack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // alu given as {V,C,N,Z}
    task automatic drive(input logic [3:0] mask, input logic [3:0] alu,
                         input logic sc, input logic cc,
                         input logic jv, input logic [2:0] jt,
                         input logic is, input logic ir);
        flagUpdateMask = mask;
        {aluOverflow, aluCarry, aluNegative, aluZero} = alu;
        setCarry   = sc;
        clearCarry = cc;
        jumpValid  = jv;
        jumpType   = jt;
        intSave    = is;
        intRestore = ir;
    endtask

    // Queue expectations, check takeJump before the edge, the rest after it.
    task automatic step(input string tag, input logic take, input logic [3:0] eccr,
                        input logic full, input logic empty, input logic err);
        exp_t e;
        sb.push_back('{tag, take, eccr, full, empty, err});
        @(negedge clk);
        chk({tag, ".take"}, {3'b0, takeJump}, {3'b0, take});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty got=0 exp=1", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".ccr"},   ccr,                 e.ccr);
            chk({e.tag, ".full"},  {3'b0, stackFull},   {3'b0, e.full});
            chk({e.tag, ".empty"}, {3'b0, stackEmpty},  {3'b0, e.empty});
            chk({e.tag, ".err"},   {3'b0, errStack},    {3'b0, e.err});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 0, 0);
        @(posedge clk);
        #1;
        step("reset", 0, 4'b0000, 0, 1, 0);
        rst_n = 1'b1;

        // ALU write of all flags, then JC consumes C
        drive(4'b1111, 4'b1100, 0, 0, 0, 3'd0, 0, 0);
        step("alu_all", 0, 4'b1100, 0, 1, 0);
        drive(4'b0000, 4'b0000, 0, 0, 1, 3'd3, 0, 0);
        step("jc_taken", 1, 4'b1000, 0, 1, 0);

        // JZ clear beats same-cycle ALU Z write; JN not taken
        drive(4'b1111, 4'b0001, 0, 0, 0, 3'd0, 0, 0);
        step("set_z", 0, 4'b0001, 0, 1, 0);
        drive(4'b0001, 4'b0001, 0, 0, 1, 3'd1, 0, 0);
        step("jz_clear", 1, 4'b0000, 0, 1, 0);
        drive(4'b0000, 4'b0000, 0, 0, 1, 3'd2, 0, 0);
        step("jn_not", 0, 4'b0000, 0, 1, 0);

        // JMP clears nothing; reserved type never jumps
        drive(4'b1111, 4'b0111, 0, 0, 0, 3'd0, 0, 0);
        step("set_0111", 0, 4'b0111, 0, 1, 0);
        drive(4'b0000, 4'b0000, 0, 0, 1, 3'd4, 0, 0);
        step("jmp", 1, 4'b0111, 0, 1, 0);
        drive(4'b0000, 4'b0000, 0, 0, 1, 3'd5, 0, 0);
        step("reserved", 0, 4'b0111, 0, 1, 0);

        // SETC/CLRC
        drive(4'b0000, 4'b0000, 1, 1, 0, 3'd0, 0, 0);
        step("setc_clrc", 0, 4'b0011, 0, 1, 0);
        drive(4'b0100, 4'b0000, 1, 0, 0, 3'd0, 0, 0);
        step("setc_over_alu", 0, 4'b0111, 0, 1, 0);

        // pop on empty: error, ccr untouched
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 0, 1);
        step("pop_empty", 0, 4'b0111, 0, 1, 1);

        // one saved entry, then reset with JMP pending
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 1, 0);
        step("push_pre_rst", 0, 4'b0111, 0, 0, 1);
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 0, 0, 1, 3'd4, 0, 0);
        step("rst_mid", 0, 4'b0000, 0, 1, 0);
        rst_n = 1'b1;

        // nested saves, overflow, and restores
        drive(4'b1111, 4'b0101, 0, 0, 0, 3'd0, 0, 0);
        step("set_0101", 0, 4'b0101, 0, 1, 0);
        drive(4'b1111, 4'b1010, 0, 0, 0, 3'd0, 1, 0);
        step("save1", 0, 4'b1010, 0, 0, 0);
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 1, 0);
        step("save2", 0, 4'b1010, 1, 0, 0);
        step("save3_full", 0, 4'b1010, 1, 0, 1);
        drive(4'b1111, 4'b0000, 0, 0, 0, 3'd0, 0, 1);
        step("restore1", 0, 4'b1010, 0, 0, 1);
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 0, 1);
        step("restore2", 0, 4'b0101, 0, 1, 1);

        // tail-chain: save+restore leaves the stack, ALU still writes
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 1, 0);
        step("push_tc", 0, 4'b0101, 0, 0, 1);
        drive(4'b1111, 4'b0011, 0, 0, 0, 3'd0, 1, 1);
        step("tail_chain", 0, 4'b0011, 0, 0, 1);
        drive(4'b0000, 4'b0000, 0, 0, 0, 3'd0, 0, 1);
        step("restore_tc", 0, 4'b0101, 0, 1, 1);
        drive(4'b0001, 4'b0000, 0, 0, 0, 3'd0, 0, 1);
        step("pop_empty_alu", 0, 4'b0100, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
